// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, centre-sampling bit FSM,
// single-byte holding register with valid/ack handshake and error flags.
module uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_ZERO = TW'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t          state_r;
    logic [1:0]      sync_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      idx_r;
    logic [7:0]      shreg_r;
    logic            rx_s;
    logic            stop_tick_s;
    logic            load_s;
    logic            ferr_s;

    assign rx_s = sync_r[1];

    // Decode the stop-bit sampling instant into load / framing-error events.
    always_comb begin
        stop_tick_s = 1'b0;
        load_s      = 1'b0;
        ferr_s      = 1'b0;
        if ((state_r == STOP) && (timer_r == T_LAST)) begin
            stop_tick_s = 1'b1;
            load_s      = rx_s;
            ferr_s      = ~rx_s;
        end else begin
            stop_tick_s = 1'b0;
        end
    end

    // Synchroniser, receive FSM, holding register and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r    <= 2'b11;
            state_r   <= IDLE;
            timer_r   <= T_ZERO;
            idx_r     <= 3'd0;
            shreg_r   <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], rx};
            frame_err <= ferr_s;

            // A completing byte takes priority over a same-cycle ack.
            if (load_s) begin
                data    <= shreg_r;
                valid   <= 1'b1;
                overrun <= valid & ~ack;
            end else if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end else begin
                valid   <= valid;
                overrun <= overrun;
            end

            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r <= START;
                        timer_r <= T_ZERO;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (timer_r == T_HALF) begin
                        timer_r <= T_ZERO;
                        idx_r   <= 3'd0;
                        if (rx_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                DATA: begin
                    if (timer_r == T_LAST) begin
                        shreg_r[idx_r] <= rx_s;
                        timer_r        <= T_ZERO;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                STOP: begin
                    if (stop_tick_s) begin
                        timer_r <= T_ZERO;
                        if (rx_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= WAIT_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line must return high before a new start edge counts.
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= T_ZERO;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, with a byte-level
// reference model of the holding register, valid and overrun flags.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_fall      = 0;
    int t_valid     = 0;
    int fe_cycles   = 0;
    logic valid_q   = 1'b0;

    // Reference model: state of the holding register as seen by the consumer.
    logic [7:0] m_data    = 8'h00;
    logic       m_valid   = 1'b0;
    logic       m_overrun = 1'b0;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .ack(ack), .data(data), .valid(valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: valid rising edge timestamp and total frame_err-high cycles.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cycles <= fe_cycles + 1;
        if (valid === 1'b1 && valid_q !== 1'b1) t_valid <= cyc;
        valid_q <= valid;
    end

    task automatic model_good(input logic [7:0] b);
        m_overrun = m_valid;
        m_valid   = 1'b1;
        m_data    = b;
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        rx = 1'b0;
        t_fall = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        model_ack();
    endtask

    task automatic check_model(input string name);
        vectors++;
        if (data !== m_data || valid !== m_valid || overrun !== m_overrun) begin
            miscompares++;
            $display("FAIL %s: got data=%h valid=%b overrun=%b, want data=%h valid=%b overrun=%b",
                     name, data, valid, overrun, m_data, m_valid, m_overrun);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if ({data, valid, frame_err, overrun, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0",
                     data, valid, frame_err, overrun, busy);
        end
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_1000: got busy=%b valid=%b, want 0 0", busy, valid);
        end
        pulse_ack();
        check_model("ack_while_empty");
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, CPB);
        model_good(8'hA5);
        repeat (4) @(negedge clk);
        check_model("basic_A5");
        vectors++;
        if ((t_valid - t_fall) < 154 || (t_valid - t_fall) > 156) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, want 155 +/-1", t_valid - t_fall);
        end
        pulse_ack();
        check_model("basic_ack");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1, CPB); model_good(8'h00);
        send_frame(8'hFF, 1'b1, CPB); model_good(8'hFF);
        send_frame(8'h3C, 1'b1, CPB); model_good(8'h3C);
        repeat (4) @(negedge clk);
        vectors++;
        if (data !== 8'h3C || valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overrun: got data=%h v=%b ov=%b, want 3c 1 1", data, valid, overrun);
        end
        pulse_ack();
        check_model("b2b_ack");
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_cycles;
        send_frame(8'h55, 1'b0, 40 * CPB);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL break_busy: got busy=%b, want 1", busy);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (fe_cycles - fe0 !== 1 || valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err: got fe_cycles=%0d valid=%b busy=%b, want 1 0 0",
                     fe_cycles - fe0, valid, busy);
        end
        send_frame(8'h12, 1'b1, CPB);
        model_good(8'h12);
        repeat (4) @(negedge clk);
        check_model("after_break_12");
    endtask

    task automatic test_glitch();
        int fe0;
        logic saw_busy;
        fe0 = fe_cycles;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        rx = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        vectors++;
        if (saw_busy !== 1'b1 || busy !== 1'b0 || fe_cycles !== fe0) begin
            miscompares++;
            $display("FAIL glitch: got saw_busy=%b busy=%b fe_delta=%0d, want 1 0 0",
                     saw_busy, busy, fe_cycles - fe0);
        end
        check_model("glitch_no_byte");
    endtask

    task automatic test_reset_mid();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        vectors++;
        if ({data, valid, frame_err, overrun, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0",
                     data, valid, frame_err, overrun, busy);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hC3, 1'b1, CPB);
        model_good(8'hC3);
        repeat (4) @(negedge clk);
        check_model("after_reset_C3");
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, CPB);
            model_good(b);
            repeat ($urandom_range(2, 20)) @(negedge clk);
            check_model("random_byte");
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                check_model("random_ack");
            end
        end
        pulse_ack();
        check_model("random_final_ack");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
